// File: rtl/pattern_match_ctrl.sv
// Programmable serial pattern detector: software loads pattern/length/overlap/threshold,
// arms a run, and the block counts matches and raises a sticky irq at the threshold.
module pattern_match_ctrl #(
  parameter int unsigned MAXLEN = 8,
  parameter int unsigned CNTW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [MAXLEN-1:0] cfg_pat,
  input  logic [3:0]        cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNTW-1:0]   cfg_thresh,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  input  logic              in,
  output logic              match,
  output logic              busy,
  output logic              done,
  output logic [CNTW-1:0]   match_cnt,
  output logic              irq,
  input  logic              irq_clr
);

  localparam logic [3:0] MaxLen4 = 4'(MAXLEN);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [MAXLEN-1:0] pat_q, pat_d;
  logic [3:0]        len_q, len_d;
  logic              ovl_q, ovl_d;
  logic [CNTW-1:0]   thresh_q, thresh_d;
  logic [MAXLEN-1:0] hist_q, hist_d;
  logic [3:0]        fill_q, fill_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              match_q, match_d;
  logic              irq_q, irq_d;

  logic [MAXLEN-1:0] cand;
  logic [MAXLEN-1:0] mask;
  logic              hit;
  logic              irq_set;
  logic [CNTW-1:0]   cnt_inc;
  logic [3:0]        fill_inc;

  // Window formed by the newest len bits, including the bit arriving this cycle.
  always_comb begin
    cand = {hist_q[MAXLEN-2:0], in};
    mask = '0;
    for (int i = 0; i < int'(MAXLEN); i++) begin
      mask[i] = (i < int'(len_q));
    end
    hit = (state_q == StRun) && in_valid && (len_q != 4'd0) &&
          (({1'b0, fill_q} + 5'd1) >= {1'b0, len_q}) &&
          (((cand ^ pat_q) & mask) == '0);
  end

  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign fill_inc = (fill_q == MaxLen4) ? fill_q : fill_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    thresh_d = thresh_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    match_d  = 1'b0;
    irq_set  = 1'b0;

    if (cfg_we && (state_q == StIdle)) begin
      pat_d    = cfg_pat;
      len_d    = (cfg_len > MaxLen4) ? MaxLen4 : cfg_len;
      ovl_d    = cfg_overlap;
      thresh_d = cfg_thresh;
    end

    case (state_q)
      StIdle, StDone: begin
        if (stop) begin
          state_d = StIdle;
        end else if (start) begin
          state_d = StRun;
          hist_d  = '0;
          fill_d  = '0;
          cnt_d   = '0;
        end
      end
      StRun: begin
        // stop wins over a match completing in the same cycle
        if (stop) begin
          state_d = StIdle;
        end else if (in_valid) begin
          hist_d = cand;
          fill_d = (hit && !ovl_q) ? 4'd0 : fill_inc;
          if (hit) begin
            match_d = 1'b1;
            cnt_d   = cnt_inc;
            if ((thresh_q != '0) && (cnt_inc == thresh_q)) begin
              state_d = StDone;
              irq_set = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    irq_d = irq_set ? 1'b1 : (irq_clr ? 1'b0 : irq_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      pat_q    <= '0;
      len_q    <= '0;
      ovl_q    <= 1'b0;
      thresh_q <= '0;
      hist_q   <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      match_q  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      ovl_q    <= ovl_d;
      thresh_q <= thresh_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      match_q  <= match_d;
      irq_q    <= irq_d;
    end
  end

  assign match     = match_q;
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign match_cnt = cnt_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_pattern_match_ctrl.sv
// Directed self-checking bench for pattern_match_ctrl.
module tb_pattern_match_ctrl;

  localparam int unsigned MAXLEN = 8;
  localparam int unsigned CNTW   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_we = 1'b0;
  logic [MAXLEN-1:0] cfg_pat = '0;
  logic [3:0]        cfg_len = '0;
  logic              cfg_overlap = 1'b0;
  logic [CNTW-1:0]   cfg_thresh = '0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              in_valid = 1'b0;
  logic              in = 1'b0;
  logic              match;
  logic              busy;
  logic              done;
  logic [CNTW-1:0]   match_cnt;
  logic              irq;
  logic              irq_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  pattern_match_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh), .start(start), .stop(stop),
    .in_valid(in_valid), .in(in), .match(match), .busy(busy), .done(done),
    .match_cnt(match_cnt), .irq(irq), .irq_clr(irq_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [7:0] p, input logic [3:0] l, input logic o,
                           input logic [7:0] t);
    cfg_we = 1'b1; cfg_pat = p; cfg_len = l; cfg_overlap = o; cfg_thresh = t;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic clr, input logic stp, output logic m);
    in = b; in_valid = 1'b1; irq_clr = clr; stop = stp;
    tick();
    m = match;
    in_valid = 1'b0; irq_clr = 1'b0; stop = 1'b0;
  endtask

  // bits are sent MSB first; pulses[n-1-i] records the match seen after the i-th bit
  task automatic send_stream(input logic [15:0] bits, input int n, input logic gaps,
                             output logic [15:0] pulses, output int gap_pulses);
    logic m;
    pulses = '0;
    gap_pulses = 0;
    for (int i = 0; i < n; i++) begin
      send_bit(bits[n-1-i], 1'b0, 1'b0, m);
      pulses[n-1-i] = m;
      if (gaps) begin
        tick();
        if (match) gap_pulses++;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (match !== 1'b0) begin failures++; $display("FAIL reset_match got=%b exp=0", match); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (match_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", match_cnt); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
  endtask

  task automatic test_overlap();
    logic [15:0] p; int g;
    configure(8'b0101, 4'd4, 1'b1, 8'd0);
    pulse_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy got=%b exp=1", busy); end
    send_stream(16'b01010101, 8, 1'b0, p, g);
    checks++; if (p !== 16'b00010101) begin failures++; $display("FAIL t1_pulses got=%b exp=%b", p, 16'b00010101); end
    checks++; if (match_cnt !== 8'd3) begin failures++; $display("FAIL t1_cnt got=%0d exp=3", match_cnt); end
    pulse_stop();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t1_stop_busy got=%b exp=0", busy); end
    checks++; if (match_cnt !== 8'd3) begin failures++; $display("FAIL t1_cnt_kept got=%0d exp=3", match_cnt); end
  endtask

  task automatic test_nonoverlap();
    logic [15:0] p; int g;
    configure(8'b0101, 4'd4, 1'b0, 8'd0);
    pulse_start();
    checks++; if (match_cnt !== 8'd0) begin failures++; $display("FAIL t2_cnt_cleared got=%0d exp=0", match_cnt); end
    send_stream(16'b01010101, 8, 1'b0, p, g);
    checks++; if (p !== 16'b00010001) begin failures++; $display("FAIL t2_pulses got=%b exp=%b", p, 16'b00010001); end
    checks++; if (match_cnt !== 8'd2) begin failures++; $display("FAIL t2_cnt got=%0d exp=2", match_cnt); end
    pulse_stop();
  endtask

  task automatic test_thresh();
    logic [15:0] p; int g; logic m;
    configure(8'b0101, 4'd4, 1'b1, 8'd2);
    pulse_start();
    send_stream(16'b01010, 5, 1'b0, p, g);
    checks++; if (p !== 16'b00010) begin failures++; $display("FAIL t3_first_pulses got=%b exp=00010", p); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL t3_early_done got=%b exp=0", done); end
    // completing bit with irq_clr asserted: set must win
    send_bit(1'b1, 1'b1, 1'b0, m);
    checks++; if (m !== 1'b1) begin failures++; $display("FAIL t3_match6 got=%b exp=1", m); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL t3_done got=%b exp=1", done); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL t3_irq_set_wins got=%b exp=1", irq); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t3_busy got=%b exp=0", busy); end
    checks++; if (match_cnt !== 8'd2) begin failures++; $display("FAIL t3_cnt got=%0d exp=2", match_cnt); end
    send_bit(1'b0, 1'b0, 1'b0, m);
    send_bit(1'b1, 1'b0, 1'b0, m);
    checks++; if (m !== 1'b0) begin failures++; $display("FAIL t3_no_match_in_done got=%b exp=0", m); end
    checks++; if (match_cnt !== 8'd2) begin failures++; $display("FAIL t3_cnt_frozen got=%0d exp=2", match_cnt); end
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL t3_irq_clr got=%b exp=0", irq); end
    pulse_start();
    checks++; if (busy !== 1'b1 || match_cnt !== 8'd0) begin
      failures++; $display("FAIL t3_restart busy=%b cnt=%0d exp busy=1 cnt=0", busy, match_cnt);
    end
    pulse_stop();
  endtask

  task automatic test_gaps();
    logic [15:0] p; int g;
    configure(8'b0101, 4'd4, 1'b1, 8'd0);
    pulse_start();
    send_stream(16'b01010101, 8, 1'b1, p, g);
    checks++; if (p !== 16'b00010101) begin failures++; $display("FAIL t4_pulses got=%b exp=%b", p, 16'b00010101); end
    checks++; if (g !== 0) begin failures++; $display("FAIL t4_gap_pulses got=%0d exp=0", g); end
    checks++; if (match_cnt !== 8'd3) begin failures++; $display("FAIL t4_cnt got=%0d exp=3", match_cnt); end
    pulse_stop();
  endtask

  task automatic test_cfg_in_run();
    logic [15:0] p; int g;
    configure(8'b0101, 4'd4, 1'b1, 8'd0);
    pulse_start();
    configure(8'b1111, 4'd4, 1'b0, 8'd1);
    send_stream(16'b01010101, 8, 1'b0, p, g);
    checks++; if (p !== 16'b00010101) begin failures++; $display("FAIL t5_cfg_ignored got=%b exp=%b", p, 16'b00010101); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL t5_thresh_ignored got=%b exp=0", done); end
    pulse_stop();
    configure(8'b0000, 4'd0, 1'b1, 8'd0);
    pulse_start();
    send_stream(16'b00000000, 8, 1'b0, p, g);
    checks++; if (match_cnt !== 8'd0) begin failures++; $display("FAIL t5_len0 got=%0d exp=0", match_cnt); end
    pulse_stop();
    // length above MAXLEN clamps to MAXLEN
    configure(8'hA5, 4'd15, 1'b1, 8'd0);
    pulse_start();
    send_stream(16'b10100101, 8, 1'b0, p, g);
    checks++; if (p !== 16'b00000001) begin failures++; $display("FAIL t5_len_clamp got=%b exp=00000001", p); end
    pulse_stop();
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] p; int g;
    configure(8'b01, 4'd2, 1'b1, 8'd0);
    pulse_start();
    send_stream(16'b010, 3, 1'b0, p, g);
    checks++; if (match_cnt !== 8'd1) begin failures++; $display("FAIL t6_pre_cnt got=%0d exp=1", match_cnt); end
    #1 rst = 1'b0;
    #1;
    checks++; if ({match, busy, done, irq} !== 4'b0000 || match_cnt !== 8'd0) begin
      failures++;
      $display("FAIL t6_async_reset m=%b b=%b d=%b i=%b cnt=%0d exp all 0", match, busy, done, irq, match_cnt);
    end
    @(posedge clk); #1 rst = 1'b1;
    pulse_start();
    send_stream(16'b0101, 4, 1'b0, p, g);
    checks++; if (match_cnt !== 8'd0) begin failures++; $display("FAIL t6_cfg_reset got=%0d exp=0", match_cnt); end
    pulse_stop();
    configure(8'b0101, 4'd4, 1'b1, 8'd0);
    pulse_start();
    send_stream(16'b01010101, 8, 1'b0, p, g);
    checks++; if (p !== 16'b00010101 || match_cnt !== 8'd3) begin
      failures++; $display("FAIL t6_clean_rerun pulses=%b cnt=%0d exp 00010101 cnt=3", p, match_cnt);
    end
    pulse_stop();
  endtask

  task automatic test_stop_match();
    logic [15:0] p; int g; logic m;
    configure(8'b0101, 4'd4, 1'b1, 8'd1);
    pulse_start();
    send_stream(16'b010, 3, 1'b0, p, g);
    send_bit(1'b1, 1'b0, 1'b1, m);
    checks++; if (m !== 1'b0) begin failures++; $display("FAIL stop_match_pulse got=%b exp=0", m); end
    checks++; if ({busy, done, irq} !== 3'b000) begin
      failures++; $display("FAIL stop_match_state b=%b d=%b i=%b exp 000", busy, done, irq);
    end
    checks++; if (match_cnt !== 8'd0) begin failures++; $display("FAIL stop_match_cnt got=%0d exp=0", match_cnt); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_thresh();
    test_gaps();
    test_cfg_in_run();
    test_reset_mid_run();
    test_stop_match();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
